// File: rtl/apu_core_dispatcher.sv
// Core-side initiator for the shared APU interconnect: holds one request until
// granted, tracks issued ops in an in-order tag FIFO and stalls decode as needed.
module apu_core_dispatcher #(
  parameter int NARGS    = 3,
  parameter int WOP      = 6,
  parameter int WAPUTYPE = 3,
  parameter int NDSFLAGS = 3,
  parameter int NUSFLAGS = 8,
  parameter int WREGADDR = 6,
  parameter int DEPTH    = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic [WAPUTYPE-1:0]   apu_type_i,
  input  logic [WOP-1:0]        apu_op_i,
  input  logic [NARGS*32-1:0]   operands_i,
  input  logic [NDSFLAGS-1:0]   flags_i,
  input  logic [WREGADDR-1:0]   waddr_i,
  input  logic [3*WREGADDR-1:0] read_regs_i,
  input  logic [2:0]            read_regs_valid_i,
  output logic                  stall_o,
  output logic                  active_o,
  output logic                  apu_req_o,
  input  logic                  apu_gnt_i,
  output logic [WAPUTYPE-1:0]   apu_type_o,
  output logic [WOP-1:0]        apu_op_o,
  output logic [NARGS*32-1:0]   apu_operands_o,
  output logic [NDSFLAGS-1:0]   apu_flags_o,
  input  logic                  apu_rvalid_i,
  input  logic [31:0]           apu_result_i,
  input  logic [NUSFLAGS-1:0]   apu_rflags_i,
  output logic                  wb_valid_o,
  output logic [WREGADDR-1:0]   wb_waddr_o,
  output logic [31:0]           wb_result_o,
  output logic [NUSFLAGS-1:0]   wb_flags_o,
  output logic                  protocol_err_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_OCC = (CW + 1)'(DEPTH);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t              state;
  logic [WREGADDR-1:0] pending_waddr;
  logic [WREGADDR-1:0] tag_mem [DEPTH];
  logic [DEPTH-1:0]    tag_vld;
  logic [PW-1:0]       wptr;
  logic [PW-1:0]       rptr;
  logic [CW-1:0]       count;

  logic                push;
  logic                pop;
  logic                full;
  logic                hazard;
  logic                blocked_req;
  logic                accept;
  logic [CW:0]         occ_after;
  logic [WREGADDR-1:0] rr;

  assign push        = apu_req_o & apu_gnt_i;
  assign pop         = apu_rvalid_i & (count != '0);
  assign blocked_req = apu_req_o & ~apu_gnt_i;

  // Occupancy once this cycle's pop has freed its slot; a grant only moves the
  // pending op into the FIFO, so it leaves the total unchanged.
  assign occ_after = {1'b0, count} + {{CW{1'b0}}, apu_req_o} - {{CW{1'b0}}, pop};
  assign full      = (occ_after == DEPTH_OCC);

  // Conservative RAW check: the head still counts even while it pops.
  always_comb begin
    hazard = 1'b0;
    rr     = '0;
    for (int k = 0; k < 3; k++) begin
      if (read_regs_valid_i[k]) begin
        rr = read_regs_i[k*WREGADDR +: WREGADDR];
        if (apu_req_o && (pending_waddr == rr)) hazard = 1'b1;
        for (int e = 0; e < DEPTH; e++) begin
          if (tag_vld[e] && (tag_mem[e] == rr)) hazard = 1'b1;
        end
      end
    end
  end

  assign stall_o  = ~rst_i & enable_i & (blocked_req | full | hazard);
  assign accept   = enable_i & ~stall_o;
  assign active_o = apu_req_o | (count != '0);

  assign wb_valid_o  = ~rst_i & pop;
  assign wb_waddr_o  = tag_mem[rptr];
  assign wb_result_o = apu_result_i;
  assign wb_flags_o  = apu_rflags_i;

  // NOTE: tag storage is qualified by tag_vld and the pointers, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (push) tag_mem[wptr] <= pending_waddr;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every read
  // below sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      apu_req_o      <= 1'b0;
      apu_type_o     <= '0;
      apu_op_o       <= '0;
      apu_operands_o <= '0;
      apu_flags_o    <= '0;
      pending_waddr  <= '0;
      wptr           <= '0;
      rptr           <= '0;
      count          <= '0;
      tag_vld        <= '0;
      protocol_err_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= REQ;
            apu_req_o <= 1'b1;
          end
        end
        REQ: begin
          if (apu_gnt_i && !accept) begin
            state     <= IDLE;
            apu_req_o <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          apu_req_o <= 1'b0;
        end
      endcase

      if (accept) begin
        apu_type_o     <= apu_type_i;
        apu_op_o       <= apu_op_i;
        apu_operands_o <= operands_i;
        apu_flags_o    <= flags_i;
        pending_waddr  <= waddr_i;
      end

      // Push and pop never address the same slot: pop needs count>0 and a
      // pending request implies count<DEPTH.
      if (pop) begin
        tag_vld[rptr] <= 1'b0;
        rptr          <= rptr + PW'(1);
      end
      if (push) begin
        tag_vld[wptr] <= 1'b1;
        wptr          <= wptr + PW'(1);
      end

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (apu_rvalid_i && (count == '0)) protocol_err_o <= 1'b1;
    end
  end

endmodule
